// File: rtl/jtcommando_prog.sv
// ---------------------------------------------------------------------------
// jtcommando_prog
//   Routes the ROM download stream either to SDRAM or to the on-chip
//   colour/timing PROMs.
//   - SDRAM bytes are queued in a two-entry FIFO. The head entry is held on
//     prog_addr/prog_data/prog_mask with prog_we high until sdram_ack pops it.
//   - PROM bytes produce a one-cycle one-hot prom_we strobe, together with
//     prom_addr and prom_din.
//   - A small FSM (IDLE/LOAD/DRAIN) pulses dwn_done once every byte of a
//     finished download has been committed.
//
// Ports
//   clk          in   system clock
//   rst          in   synchronous active-high reset
//   downloading  in   high while the ROM file is being transferred
//   ioctl_addr   in   [21:0] byte address of the incoming byte
//   ioctl_data   in   [7:0]  incoming byte
//   ioctl_wr     in   one-cycle byte-valid strobe
//   prog_addr    out  [21:0] SDRAM word address
//   prog_data    out  [7:0]  byte to write
//   prog_mask    out  [1:0]  active-low byte mask
//   prog_we      out  SDRAM write request (level)
//   sdram_ack    in   SDRAM controller accepted the current request
//   prom_we      out  [7:0]  one-hot PROM write strobe
//   prom_addr    out  [7:0]  PROM address
//   prom_din     out  [3:0]  PROM data
//   overflow     out  sticky: an SDRAM byte was dropped
//   dwn_done     out  one-cycle pulse: download fully committed
// ---------------------------------------------------------------------------
module jtcommando_prog #(
  parameter logic [21:0] PROM_START = 22'h38000,
  parameter int unsigned PROM_CNT   = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        downloading,
  input  logic [21:0] ioctl_addr,
  input  logic [7:0]  ioctl_data,
  input  logic        ioctl_wr,
  output logic [21:0] prog_addr,
  output logic [7:0]  prog_data,
  output logic [1:0]  prog_mask,
  output logic        prog_we,
  input  logic        sdram_ack,
  output logic [7:0]  prom_we,
  output logic [7:0]  prom_addr,
  output logic [3:0]  prom_din,
  output logic        overflow,
  output logic        dwn_done
);

  typedef struct packed {
    logic [21:0] addr;
    logic [7:0]  data;
    logic [1:0]  mask;
  } entry_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DRAIN
  } state_t;

  localparam entry_t     ENTRY_RST = '{addr: '0, data: '0, mask: 2'b11};
  localparam logic [22:0] PROM_END = {1'b0, PROM_START} + 23'(PROM_CNT * 256);

  // -------------------------------------------------------------------------
  // Download edge detection and region decode
  // -------------------------------------------------------------------------
  logic dl_q;
  logic dl_rise;
  logic accept;
  logic sdram_hit;
  logic prom_hit;
  logic [10:0] prom_off;
  entry_t new_entry;

  // dl_q follows the input even through reset: a download that spans a reset
  // must not look like a fresh rise afterwards, so the aborted transfer can
  // never produce dwn_done.
  always_ff @(posedge clk) begin
    dl_q <= downloading;
  end

  assign dl_rise = downloading & ~dl_q;
  // A byte strobed in the very cycle downloading drops is still taken.
  assign accept    = ioctl_wr & (downloading | dl_q);
  assign sdram_hit = accept & (ioctl_addr < PROM_START);
  assign prom_hit  = accept & ({1'b0, ioctl_addr} >= {1'b0, PROM_START})
                            & ({1'b0, ioctl_addr} < PROM_END);
  // Only offset bits [10:8] (PROM select) and [7:0] (address) matter.
  assign prom_off  = ioctl_addr[10:0] - PROM_START[10:0];

  assign new_entry = '{addr: {1'b0, ioctl_addr[21:1]},
                       data: ioctl_data,
                       mask: ioctl_addr[0] ? 2'b01 : 2'b10};

  // -------------------------------------------------------------------------
  // Two-entry FIFO: head_q is always the entry presented to SDRAM
  // -------------------------------------------------------------------------
  logic [1:0] count_q, count_d;
  entry_t     head_q, head_d;
  entry_t     tail_q, tail_d;
  logic       push, pop, ovf_set;
  logic       overflow_q, overflow_d;

  assign push = sdram_hit;
  assign pop  = sdram_ack & (count_q != 2'd0);

  // NOTE: every signal assigned in an always_comb gets a default first so
  // no path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    count_d = count_q;
    head_d  = head_q;
    tail_d  = tail_q;
    ovf_set = 1'b0;
    case ({push, pop})
      2'b10: begin
        case (count_q)
          2'd0:    begin head_d = new_entry; count_d = 2'd1; end
          2'd1:    begin tail_d = new_entry; count_d = 2'd2; end
          default: ovf_set = 1'b1;
        endcase
      end
      2'b01: begin
        count_d = count_q - 2'd1;
        if (count_q == 2'd2) head_d = tail_q;
      end
      2'b11: begin
        // Occupancy unchanged; the new byte lands behind whatever remains.
        if (count_q == 2'd1) begin
          head_d = new_entry;
        end else begin
          head_d = tail_q;
          tail_d = new_entry;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    overflow_d = overflow_q;
    if (dl_rise) overflow_d = 1'b0;
    if (ovf_set) overflow_d = 1'b1;
  end

  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q    <= 2'd0;
      head_q     <= ENTRY_RST;
      overflow_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      head_q     <= head_d;
      overflow_q <= overflow_d;
    end
  end

  // NOTE: the tail slot is plain storage qualified by count_q, so it carries
  // no reset; clearing it would only add reset fan-out with no visible effect.
  always_ff @(posedge clk) begin
    tail_q <= tail_d;
  end

  assign prog_addr = head_q.addr;
  assign prog_data = head_q.data;
  assign prog_mask = head_q.mask;
  assign prog_we   = (count_q != 2'd0);
  assign overflow  = overflow_q;

  // -------------------------------------------------------------------------
  // PROM write port: strobe one cycle after the accepted byte
  // -------------------------------------------------------------------------
  logic [7:0] prom_we_q, prom_we_d;
  logic [7:0] prom_addr_q, prom_addr_d;
  logic [3:0] prom_din_q, prom_din_d;

  always_comb begin
    prom_we_d   = 8'd0;
    prom_addr_d = prom_addr_q;
    prom_din_d  = prom_din_q;
    if (prom_hit) begin
      prom_we_d   = 8'd1 << prom_off[10:8];
      prom_addr_d = prom_off[7:0];
      prom_din_d  = ioctl_data[3:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prom_we_q   <= 8'd0;
      prom_addr_q <= 8'd0;
      prom_din_q  <= 4'd0;
    end else begin
      prom_we_q   <= prom_we_d;
      prom_addr_q <= prom_addr_d;
      prom_din_q  <= prom_din_d;
    end
  end

  assign prom_we   = prom_we_q;
  assign prom_addr = prom_addr_q;
  assign prom_din  = prom_din_q;

  // -------------------------------------------------------------------------
  // Download FSM
  // -------------------------------------------------------------------------
  state_t state_q, state_d;
  logic   dwn_done_q, dwn_done_d;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      dwn_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      dwn_done_q <= dwn_done_d;
    end
  end

  // Next state. Decisions use count_d so that a byte accepted in the falling
  // cycle, or the final pop, is accounted for on the same edge.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (dl_rise) state_d = S_LOAD;
      end
      S_LOAD: begin
        if (!downloading) state_d = (count_d == 2'd0) ? S_IDLE : S_DRAIN;
      end
      S_DRAIN: begin
        if (downloading)            state_d = S_LOAD;
        else if (count_d == 2'd0)   state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs: dwn_done is registered, so it appears in the first cycle the
  // FSM sits in IDLE after a completed download.
  always_comb begin
    dwn_done_d = (state_q != S_IDLE) && (state_d == S_IDLE);
  end

  assign dwn_done = dwn_done_q;

endmodule

// File: tb/tb_jtcommando_prog.sv
module tb_jtcommando_prog;

  localparam logic [21:0] PSTART = 22'h38000;
  localparam logic [21:0] PEND   = 22'h38600;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        downloading = 1'b0;
  logic [21:0] ioctl_addr = '0;
  logic [7:0]  ioctl_data = '0;
  logic        ioctl_wr = 1'b0;
  logic [21:0] prog_addr;
  logic [7:0]  prog_data;
  logic [1:0]  prog_mask;
  logic        prog_we;
  logic        sdram_ack = 1'b0;
  logic [7:0]  prom_we;
  logic [7:0]  prom_addr;
  logic [3:0]  prom_din;
  logic        overflow;
  logic        dwn_done;

  always #5 clk = ~clk;

  jtcommando_prog dut (
    .clk         (clk),
    .rst         (rst),
    .downloading (downloading),
    .ioctl_addr  (ioctl_addr),
    .ioctl_data  (ioctl_data),
    .ioctl_wr    (ioctl_wr),
    .prog_addr   (prog_addr),
    .prog_data   (prog_data),
    .prog_mask   (prog_mask),
    .prog_we     (prog_we),
    .sdram_ack   (sdram_ack),
    .prom_we     (prom_we),
    .prom_addr   (prom_addr),
    .prom_din    (prom_din),
    .overflow    (overflow),
    .dwn_done    (dwn_done)
  );

  typedef struct packed {
    logic [21:0] a;
    logic [7:0]  d;
    logic [1:0]  m;
  } sd_t;

  sd_t         sd_q[$];
  logic [19:0] prom_q[$];
  int n_checks = 0;
  int n_errors = 0;
  int n_writes = 0;
  int n_done   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard side: compare each accepted SDRAM write and PROM strobe
  // against the oldest expectation.
  sd_t         mon_sd;
  logic [19:0] mon_prom;
  always @(negedge clk) begin
    if (!rst) begin
      if (prog_we && sdram_ack) begin
        check("sd_pending", 64'(sd_q.size() != 0), 64'd1);
        if (sd_q.size() != 0) begin
          mon_sd = sd_q.pop_front();
          check("sd_write", {prog_addr, prog_data, prog_mask}, mon_sd);
          n_writes++;
        end
      end
      if (prom_we != 8'd0) begin
        check("prom_pending", 64'(prom_q.size() != 0), 64'd1);
        if (prom_q.size() != 0) begin
          mon_prom = prom_q.pop_front();
          check("prom_write", {prom_we, prom_addr, prom_din}, mon_prom);
        end
      end
      if (dwn_done) n_done++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  // Drive one byte; push the expected outcome unless the byte should be lost.
  task automatic wr_byte(input logic [21:0] a, input logic [7:0] d, input bit keep);
    sd_t        e;
    logic [21:0] off;
    logic [7:0]  sel;
    ioctl_addr = a;
    ioctl_data = d;
    ioctl_wr   = 1'b1;
    if (keep) begin
      if (a < PSTART) begin
        e.a = {1'b0, a[21:1]};
        e.d = d;
        e.m = a[0] ? 2'b01 : 2'b10;
        sd_q.push_back(e);
      end else if (a < PEND) begin
        off = a - PSTART;
        sel = 8'd1 << off[10:8];
        prom_q.push_back({sel, off[7:0], d[3:0]});
      end
    end
    tick();
    ioctl_wr = 1'b0;
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_prog_we"},   prog_we,   1'b0);
    check({pfx, "_prom_we"},   prom_we,   8'd0);
    check({pfx, "_overflow"},  overflow,  1'b0);
    check({pfx, "_dwn_done"},  dwn_done,  1'b0);
    check({pfx, "_prog_addr"}, prog_addr, 22'd0);
    check({pfx, "_prog_data"}, prog_data, 8'd0);
    check({pfx, "_prog_mask"}, prog_mask, 2'b11);
    check({pfx, "_prom_addr"}, prom_addr, 8'd0);
    check({pfx, "_prom_din"},  prom_din,  4'd0);
  endtask

  int done_snap;

  initial begin
    // Reset state
    repeat (3) tick();
    at_neg();
    check_reset_outputs("rst");
    rst = 1'b0;
    downloading = 1'b1;
    tick();

    // Single SDRAM byte, ack three cycles later
    wr_byte(22'h00003, 8'hA5, 1'b1);
    for (int i = 0; i < 3; i++) begin
      at_neg();
      check("hold_req", {prog_we, prog_addr, prog_data, prog_mask},
            {1'b1, 22'h000001, 8'hA5, 2'b01});
      if (i == 2) sdram_ack = 1'b1;
      else tick();
    end
    tick();
    sdram_ack = 1'b0;
    at_neg();
    check("we_drop_after_ack", prog_we, 1'b0);

    // PROM bytes, including the first and last addresses of the window
    wr_byte(22'h38105, 8'h3C, 1'b1);
    at_neg();
    check("prom_we_02", prom_we, 8'h02);
    check("prom_no_sdram", prog_we, 1'b0);
    tick();
    at_neg();
    check("prom_we_one_cycle", prom_we, 8'h00);
    wr_byte(22'h385FF, 8'h9E, 1'b1);
    wr_byte(22'h38000, 8'h01, 1'b1);
    // Above the PROM window: ignored entirely
    wr_byte(PEND, 8'h77, 1'b1);
    at_neg();
    check("ignored_prog_we", prog_we, 1'b0);
    check("ignored_prom_we", prom_we, 8'h00);
    check("ignored_overflow", overflow, 1'b0);

    // Last SDRAM byte below PROM_START
    wr_byte(22'h37FFF, 8'h5A, 1'b1);
    sdram_ack = 1'b1;
    tick();
    sdram_ack = 1'b0;

    // Three bytes back to back without ack: third is dropped
    wr_byte(22'h00010, 8'h11, 1'b1);
    wr_byte(22'h00011, 8'h22, 1'b1);
    wr_byte(22'h00012, 8'h33, 1'b0);
    at_neg();
    check("ovf_set", overflow, 1'b1);
    check("ovf_head", {prog_addr, prog_data, prog_mask}, {22'h000008, 8'h11, 2'b10});
    sdram_ack = 1'b1;
    tick();
    tick();
    sdram_ack = 1'b0;
    at_neg();
    check("ovf_drained", prog_we, 1'b0);
    check("ovf_sticky", overflow, 1'b1);

    // End session with empty FIFO: dwn_done the next cycle
    downloading = 1'b0;
    tick();
    at_neg();
    check("done_empty_fall", dwn_done, 1'b1);
    tick();
    at_neg();
    check("done_single_pulse", dwn_done, 1'b0);
    downloading = 1'b1;
    tick();
    at_neg();
    check("ovf_clear_on_rise", overflow, 1'b0);

    // Streaming with ack every cycle
    sdram_ack = 1'b1;
    for (int i = 0; i < 16; i++) wr_byte(22'h00200 + 22'(i), 8'(i * 7 + 1), 1'b1);
    repeat (3) tick();
    sdram_ack = 1'b0;
    at_neg();
    check("stream_overflow", overflow, 1'b0);
    check("stream_drained", sd_q.size(), 0);

    // Fall with two pending entries; second byte arrives on the falling cycle
    done_snap = n_done;
    wr_byte(22'h00300, 8'hAA, 1'b1);
    downloading = 1'b0;
    wr_byte(22'h00301, 8'hBB, 1'b1);
    at_neg();
    check("drain_we", prog_we, 1'b1);
    check("drain_no_done0", dwn_done, 1'b0);
    sdram_ack = 1'b1;
    tick();
    at_neg();
    check("drain_no_done1", dwn_done, 1'b0);
    tick();
    sdram_ack = 1'b0;
    at_neg();
    check("drain_done", dwn_done, 1'b1);
    check("drain_we_low", prog_we, 1'b0);
    tick();
    at_neg();
    check("drain_done_once", n_done - done_snap, 1);

    // Reset mid-transfer
    downloading = 1'b1;
    tick();
    wr_byte(22'h00400, 8'h01, 1'b1);
    wr_byte(22'h00401, 8'h02, 1'b1);
    at_neg();
    check("abort_we_before", prog_we, 1'b1);
    rst = 1'b1;
    tick();
    sd_q.delete();
    at_neg();
    check_reset_outputs("abort");
    done_snap = n_done;
    rst = 1'b0;
    downloading = 1'b0;
    repeat (4) tick();
    wr_byte(22'h00500, 8'h55, 1'b1);
    sd_q.delete();
    at_neg();
    check("idle_wr_ignored", prog_we, 1'b0);
    tick();
    at_neg();
    check("abort_no_done", n_done - done_snap, 0);

    // Totals
    check("sd_left", sd_q.size(), 0);
    check("prom_left", prom_q.size(), 0);
    check("sd_write_total", n_writes, 22);
    check("done_total", n_done, 2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
